car_sprite_addr_gen: RTL
========================

// Module: car_sprite_addr_gen
// PURPOSE
//  Pipelined sprite-sheet address generator for car sprites. Maps a car index, a tile-local pixel and a
//  facing flag to sheet coordinates and a linear ROM address; adds animation frames, horizontal mirroring,
//  range checking and a valid/ready stream interface. Sits between the car draw logic and the sprite ROM.
// PARAMETERS
//  NUM_CARS    6    cars per sheet row (columns); CarIdx >= NUM_CARS is out of range
//  TILE_W      48   sprite tile width in pixels
//  TILE_H      67   sprite tile height in pixels (also row pitch)
//  COL_PITCH   51   horizontal pitch between car columns (tile width + gap)
//  NUM_FRAMES  2    animation frames per facing; sheet rows = 2*NUM_FRAMES
//  FRAME_DIV   4    FrameTick pulses per animation frame advance (>=1)
//  SHEET_W     512  sheet row stride in pixels for the linear address
//  COORD_W     9    width of sprite X/Y outputs
//  ADDR_W      18   width of linear ROM address
// PORTS
//  Clk             in   1        system clock
//  Reset_n         in   1        asynchronous active-low reset
//  FrameTick       in   1        one-cycle pulse per video frame
//  AnimEn          in   1        1: animation counter advances on FrameTick; 0: frame held
//  InValid         in   1        request valid
//  InReady         out  1        request accepted when InValid & InReady
//  CarIdx          in   3        car column select
//  CarTileX        in   6        pixel X inside the tile
//  CarTileY        in   7        pixel Y inside the tile
//  Reverse         in   1        facing: selects the reverse row group
//  MirrorX         in   1        1: horizontal flip, X' = TILE_W-1-CarTileX
//  OutValid        out  1        result valid
//  OutReady        in   1        result consumed when OutValid & OutReady
//  CarSpriteX      out  COORD_W  sheet X
//  CarSpriteY      out  COORD_W  sheet Y
//  SpriteAddr      out  ADDR_W   CarSpriteY*SHEET_W + CarSpriteX
//  Transparent     out  1        1: request out of range; coordinates/address forced to 0
// BEHAVIOUR
//  Reset (async assert, sync release): OutValid=0, stage valids=0, frame=0, divider=0, all data outputs 0.
//  InReady=1 after reset.
//  Animation: on FrameTick with AnimEn=1, divider increments; at FRAME_DIV-1 it clears and frame
//  increments, wrapping NUM_FRAMES-1 -> 0. AnimEn=0 holds both. FrameTick with AnimEn=0 has no effect.
//  Stage 1 (capture): on accept, registers inputs plus the current frame value. A FrameTick in the same
//  cycle affects only later requests.
//  Stage 1 computes range = (CarIdx<NUM_CARS)&(CarTileX<TILE_W)&(CarTileY<TILE_H).
//  Stage 2: Xl = MirrorX ? TILE_W-1-CarTileX : CarTileX; row = Reverse*NUM_FRAMES + frame;
//  CarSpriteX = CarIdx*COL_PITCH + Xl; CarSpriteY = row*TILE_H + CarTileY.
//  SpriteAddr = CarSpriteY*SHEET_W + CarSpriteX. Truncation: to COORD_W/ADDR_W; parameters are sized so
//  no truncation occurs at defaults. Out of range: Transparent=1, X=Y=Addr=0.
//  Latency: 2 cycles accept->OutValid with no stall; throughput 1 per cycle.
//  Handshake: a stage loads when it is empty or the stage after it advances.
//  InReady = ~V1 | ~OutValid | OutReady (combinational).
//  Stall: OutValid&~OutReady holds all outputs stable; a full pipe holds both stages, and no request is
//  dropped or duplicated.
//  Simultaneous accept and output consume: both occur; the pipe shifts.
//  Reset mid-operation: in-flight requests are discarded; no OutValid until new accepts.
// TESTING
//  T1 CarIdx=2,TileX=5,TileY=3,Rev=0,Mirror=0,frame0 -> 2 cycles later X=107,Y=3,Addr=1643,Transp=0.
//  T2 frame=1 (4 ticks, AnimEn=1), CarIdx=2,TileX=5,TileY=3,Rev=1,Mirror=1 -> X=144,Y=204,Addr=104592.
//  T3 CarIdx=6, or TileX=48, or TileY=67 -> Transparent=1, X=Y=Addr=0; next in-range request unaffected.
//  T4 8 FrameTicks AnimEn=1 -> frame 0->1->0; AnimEn=0 with 10 ticks -> frame unchanged.
//  T5 stream 5 back-to-back requests, OutReady low cycles 3-5 -> InReady=0 while full, outputs stable,
//     all 5 results emerge in order and exactly once.
//  T6 assert Reset_n=0 with 2 requests in flight -> OutValid=0 immediately; frame=0; InReady=1 on release.

Source files
------------

// File: rtl/car_sprite_addr_gen.sv
// Two-stage sprite-sheet address generator: capture/range-check, then sheet X/Y and linear ROM address.
// Valid/ready stream; frame counter advances every FRAME_DIV FrameTicks while AnimEn is high.
module car_sprite_addr_gen #(
  parameter int NUM_CARS   = 6,
  parameter int TILE_W     = 48,
  parameter int TILE_H     = 67,
  parameter int COL_PITCH  = 51,
  parameter int NUM_FRAMES = 2,
  parameter int FRAME_DIV  = 4,
  parameter int SHEET_W    = 512,
  parameter int COORD_W    = 9,
  parameter int ADDR_W     = 18
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               FrameTick,
  input  logic               AnimEn,
  input  logic               InValid,
  output logic               InReady,
  input  logic [2:0]         CarIdx,
  input  logic [5:0]         CarTileX,
  input  logic [6:0]         CarTileY,
  input  logic               Reverse,
  input  logic               MirrorX,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [COORD_W-1:0] CarSpriteX,
  output logic [COORD_W-1:0] CarSpriteY,
  output logic [ADDR_W-1:0]  SpriteAddr,
  output logic               Transparent
);

  localparam int FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NUM_FRAMES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  typedef struct packed {
    logic [2:0]       car;
    logic [5:0]       tx;
    logic [6:0]       ty;
    logic             rev;
    logic             mir;
    logic [FRM_W-1:0] frm;
    logic             rng;
  } s1_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ADDR_W-1:0]  addr;
    logic               transp;
  } s2_t;

  logic [2:1]       vld_q;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             adv2, ld1;

  // A stage loads when empty or when the stage after it drains.
  assign adv2    = ~vld_q[2] | OutReady;
  assign ld1     = ~vld_q[1] | adv2;
  assign InReady = ld1;

  always_comb begin
    frame_d = frame_q;
    div_d   = div_q;
    if (FrameTick && AnimEn) begin
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        frame_d = (frame_q == FRM_LAST) ? '0 : frame_q + FRM_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    s1_d.car = CarIdx;
    s1_d.tx  = CarTileX;
    s1_d.ty  = CarTileY;
    s1_d.rev = Reverse;
    s1_d.mir = MirrorX;
    s1_d.frm = frame_q;
    s1_d.rng = (32'(CarIdx) < 32'(NUM_CARS)) && (32'(CarTileX) < 32'(TILE_W)) &&
               (32'(CarTileY) < 32'(TILE_H));
  end

  logic [31:0] xl, row, sx, sy, sa;
  always_comb begin
    xl   = s1_q.mir ? 32'(TILE_W - 1) - 32'(s1_q.tx) : 32'(s1_q.tx);
    row  = 32'(s1_q.rev) * 32'(NUM_FRAMES) + 32'(s1_q.frm);
    sx   = 32'(s1_q.car) * 32'(COL_PITCH) + xl;
    sy   = row * 32'(TILE_H) + 32'(s1_q.ty);
    sa   = sy * 32'(SHEET_W) + sx;
    s2_d = '0;
    if (s1_q.rng) begin
      s2_d.x    = COORD_W'(sx);
      s2_d.y    = COORD_W'(sy);
      s2_d.addr = ADDR_W'(sa);
    end else begin
      s2_d.transp = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      frame_q <= '0;
      div_q   <= '0;
    end else begin
      frame_q <= frame_d;
      div_q   <= div_d;
      if (ld1) vld_q[1] <= InValid;
      if (ld1 && InValid) s1_q <= s1_d;
      if (adv2) vld_q[2] <= vld_q[1];
      if (adv2 && vld_q[1]) s2_q <= s2_d;
    end
  end

  assign OutValid    = vld_q[2];
  assign CarSpriteX  = s2_q.x;
  assign CarSpriteY  = s2_q.y;
  assign SpriteAddr  = s2_q.addr;
  assign Transparent = s2_q.transp;

endmodule
